// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: groups the two requester ports (cpu = port 0, dbg = port 1)
// and the RAM-side bus of the data-memory arbiter.
//   slave  : the arbiter's view (requests in, grants/done/rdata out, RAM bus out)
//   master : the environment's view (requesters and RAM model)
interface dm_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cpu_req, cpu_we, cpu_se, cpu_gnt, cpu_done;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic [1:0]        cpu_size;

  logic              dbg_req, dbg_we, dbg_se, dbg_gnt, dbg_done;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic [1:0]        dbg_size;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we, ram_se;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [1:0]        ram_size;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_se,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size, dbg_se,
    output dbg_gnt, dbg_done, dbg_rdata,
    output ram_addr, ram_we, ram_wdata, ram_size, ram_se,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_se,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size, dbg_se,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  ram_addr, ram_we, ram_wdata, ram_size, ram_se,
    output ram_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one synchronous data RAM between the CPU datapath
// (port 0) and the debug reader/writer (port 1). Each access is a fixed
// IDLE -> ISSUE -> WAIT transaction; ties are resolved round-robin.
// Ports:
//   clk  - clock, rising edge
//   rst_ - asynchronous reset, active high
//   bus  - dm_arbiter_if.slave: cpu_*/dbg_* requester ports, ram_* RAM bus

// Per-port response registers: gnt/done pulses and held read data.
module dm_arbiter_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              gnt_set,
  input  logic              done_set,
  input  logic              capture,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              gnt,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      gnt   <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      gnt  <= gnt_set;
      done <= done_set;
      if (capture) rdata <= ram_rdata;
    end
  end
endmodule

module dm_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst_,
  dm_arbiter_if.slave bus
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              se;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                              state, state_nxt;
  cmd_t   [NUM_PORTS-1:0]              port_cmd;
  cmd_t                                cmd_q;
  logic   [NUM_PORTS-1:0]              req, gnt_set, done_set, capture, gnt, done;
  logic   [NUM_PORTS-1:0][DATA_W-1:0]  rdata;
  logic                                owner, last, win, start;

  assign req         = {bus.dbg_req, bus.cpu_req};
  assign port_cmd[0] = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_size, bus.cpu_se};
  assign port_cmd[1] = {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata, bus.dbg_size, bus.dbg_se};

  // A tie goes to the port that did not win last; a lone requester wins.
  assign win   = (&req) ? ~last : req[1];
  assign start = (state == IDLE) && (|req);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset leaves last = dbg so the first tie favours the cpu.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      cmd_q <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
    end else if (start) begin
      cmd_q <= port_cmd[win];
      owner <= win;
      last  <= win;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_PORTS; i++) begin : g_lane
      assign gnt_set[i]  = start && (win == 1'(i));
      assign done_set[i] = (state == WAIT) && (owner == 1'(i));
      assign capture[i]  = done_set[i] && !cmd_q.we;

      dm_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
        .clk       (clk),
        .rst_      (rst_),
        .gnt_set   (gnt_set[i]),
        .done_set  (done_set[i]),
        .capture   (capture[i]),
        .ram_rdata (bus.ram_rdata),
        .gnt       (gnt[i]),
        .done      (done[i]),
        .rdata     (rdata[i])
      );
    end
  endgenerate

  assign bus.cpu_gnt   = gnt[0];
  assign bus.cpu_done  = done[0];
  assign bus.cpu_rdata = rdata[0];
  assign bus.dbg_gnt   = gnt[1];
  assign bus.dbg_done  = done[1];
  assign bus.dbg_rdata = rdata[1];

  // RAM bus follows the command registers, so it holds its value in IDLE;
  // write enable is qualified by ISSUE so it drops as soon as reset hits.
  assign bus.ram_addr  = cmd_q.addr;
  assign bus.ram_wdata = cmd_q.wdata;
  assign bus.ram_size  = cmd_q.size;
  assign bus.ram_se    = cmd_q.se;
  assign bus.ram_we    = (state == ISSUE) && cmd_q.we;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed plus random stimulus for dm_arbiter, checked
// against a transaction-level model that schedules each access as
// "grant at t+1, done at t+3" and keeps its own copy of memory.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  dm_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  // Environment RAM: synchronous read, write on ram_we.
  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state: at most one access in flight.
  int          k;
  int          p_gnt, p_done;
  logic        p_own, p_we, p_se, m_last;
  logic [7:0]  p_addr;
  logic [31:0] p_wdata, p_rdata;
  logic [1:0]  p_size;
  logic [31:0] exp_rd [2];
  logic        has_cmd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asrt++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, k);
    end
  endtask

  task automatic check_cycle();
    logic [1:0] g, d;
    logic       issue;
    issue = (k == p_gnt);
    g = issue ? (p_own ? 2'b10 : 2'b01) : 2'b00;
    d = (k == p_done) ? (p_own ? 2'b10 : 2'b01) : 2'b00;
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(g[0]));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(g[1]));
    chk("cpu_done", 32'(bus.cpu_done), 32'(d[0]));
    chk("dbg_done", 32'(bus.dbg_done), 32'(d[1]));
    chk("ram_we", 32'(bus.ram_we), 32'(issue && p_we));
    chk("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
    chk("dbg_rdata", bus.dbg_rdata, exp_rd[1]);
    if (issue) begin
      chk("ram_addr", 32'(bus.ram_addr), 32'(p_addr));
      chk("ram_wdata", bus.ram_wdata, p_wdata);
      chk("ram_size", 32'(bus.ram_size), 32'(p_size));
      chk("ram_se", 32'(bus.ram_se), 32'(p_se));
    end
  endtask

  // Model decides on the inputs currently driven, then one clock elapses.
  task automatic tick();
    logic c, g;
    c = bus.cpu_req;
    g = bus.dbg_req;
    if (k >= p_done && (c || g)) begin
      p_own  = (c && g) ? ~m_last : g;
      m_last = p_own;
      p_gnt  = k + 1;
      p_done = k + 3;
      if (p_own) begin
        p_we = bus.dbg_we; p_addr = bus.dbg_addr; p_wdata = bus.dbg_wdata;
        p_size = bus.dbg_size; p_se = bus.dbg_se;
      end else begin
        p_we = bus.cpu_we; p_addr = bus.cpu_addr; p_wdata = bus.cpu_wdata;
        p_size = bus.cpu_size; p_se = bus.cpu_se;
      end
      if (p_we) ref_mem[p_addr] = p_wdata;
      else      p_rdata = ref_mem[p_addr];
    end
    @(posedge clk);
    #1;
    k++;
    if (k == p_done && !p_we) exp_rd[p_own] = p_rdata;
    check_cycle();
  endtask

  function automatic logic granted(input logic p);
    return (k == p_gnt) && (p_own == p);
  endfunction

  task automatic set_cmd(input logic p, input logic rq, input logic we,
                         input logic [7:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic se);
    if (p) begin
      bus.dbg_req = rq; bus.dbg_we = we; bus.dbg_addr = a;
      bus.dbg_wdata = wd; bus.dbg_size = sz; bus.dbg_se = se;
    end else begin
      bus.cpu_req = rq; bus.cpu_we = we; bus.cpu_addr = a;
      bus.cpu_wdata = wd; bus.cpu_size = sz; bus.cpu_se = se;
    end
  endtask

  task automatic model_reset();
    p_gnt = -10; p_done = -10; m_last = 1'b1;
    p_we = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    ram_mem[8'h10] = 32'h12345678;
    ref_mem[8'h10] = 32'h12345678;
    k = 0;
    has_cmd[0] = 1'b0; has_cmd[1] = 1'b0;
    model_reset();
    set_cmd(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    set_cmd(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);

    // Reset state: all outputs low.
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    rst_ = 1'b0;

    // Single cpu read of 0x10.
    set_cmd(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 2'd2, 1'b0);
    tick();
    chk("t1_gnt", 32'(bus.cpu_gnt), 32'h1);
    set_cmd(1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 2'd2, 1'b0);
    tick(); tick();
    chk("t1_done", 32'(bus.cpu_done), 32'h1);
    chk("t1_rdata", bus.cpu_rdata, 32'h12345678);

    // dbg write of 0xDEADBEEF to 0x20.
    set_cmd(1'b1, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 2'd2, 1'b0);
    tick();
    chk("t2_we", 32'(bus.ram_we), 32'h1);
    set_cmd(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    tick();
    chk("t2_we_drop", 32'(bus.ram_we), 32'h0);
    tick();
    chk("t2_done", 32'(bus.dbg_done), 32'h1);

    // Simultaneous reads: cpu first, dbg 3 cycles later, cpu keeps requesting.
    rst_ = 1'b1; #1; model_reset(); rst_ = 1'b0;
    set_cmd(1'b0, 1'b1, 1'b0, 8'h20, 32'h0, 2'd2, 1'b0);
    set_cmd(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 2'd2, 1'b0);
    tick();
    chk("t3_cpu_first", 32'(bus.cpu_gnt), 32'h1);
    set_cmd(1'b0, 1'b1, 1'b0, 8'h11, 32'h0, 2'd2, 1'b0);
    tick(); tick(); tick();
    chk("t3_dbg_next", 32'(bus.dbg_gnt), 32'h1);
    set_cmd(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    repeat (3) tick();
    chk("t3_cpu_again", 32'(bus.cpu_gnt), 32'h1);

    // cpu held continuously: grants every 3 cycles.
    repeat (9) tick();
    set_cmd(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    repeat (3) tick();

    // Reset during WAIT of a cpu write.
    set_cmd(1'b0, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 2'd2, 1'b1);
    tick();
    set_cmd(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    tick();
    #2 rst_ = 1'b1;
    #1;
    model_reset();
    check_cycle();
    @(posedge clk); #1; k++;
    check_cycle();
    chk("t5_no_done", 32'(bus.cpu_done), 32'h0);
    rst_ = 1'b0;
    set_cmd(1'b0, 1'b1, 1'b0, 8'h30, 32'h0, 2'd2, 1'b0);
    tick();
    set_cmd(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    tick(); tick();
    chk("t5_recover", 32'(bus.cpu_done), 32'h1);

    // dbg pulse during cpu ISSUE is ignored.
    set_cmd(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 2'd2, 1'b0);
    tick();
    set_cmd(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    set_cmd(1'b1, 1'b1, 1'b1, 8'h40, 32'h55AA55AA, 2'd2, 1'b0);
    tick();
    set_cmd(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 2'd0, 1'b0);
    repeat (4) tick();

    // Random traffic on a small address window.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (granted(1'(p)) || (has_cmd[p] && $urandom_range(0, 15) == 0)) begin
          has_cmd[p] = ($urandom_range(0, 1) == 1);
          set_cmd(1'(p), has_cmd[p], 1'($urandom), 8'($urandom_range(0, 15)),
                  $urandom, 2'($urandom), 1'($urandom));
        end else if (!has_cmd[p] && $urandom_range(0, 2) == 0) begin
          has_cmd[p] = 1'b1;
          set_cmd(1'(p), 1'b1, 1'($urandom), 8'($urandom_range(0, 15)),
                  $urandom, 2'($urandom), 1'($urandom));
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter that shares the single data RAM between the CPU datapath (port 0, "cpu") and a debug/display reader-writer (port 1, "dbg"), which drives switch/Led/Seg inspection.
- Sits between the requesters and the RAM. Owns the RAM address, write-enable, wdata, size and sign-extend inputs.
- Sequences each access as a fixed 3-cycle transaction and resolves simultaneous requests round-robin.

Parameters:
- ADDR_W, 8: RAM byte-address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request; held with command stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_size  in  2  access size code, passed through to the RAM.
- cpu_se  in  1  sign-extend select, passed through to the RAM.
- cpu_gnt  out  1  one-cycle pulse: command accepted.
- cpu_done  out  1  one-cycle pulse: access complete.
- cpu_rdata  out  DATA_W  read result; valid while cpu_done = 1, then held.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size, dbg_se, dbg_gnt, dbg_done, dbg_rdata: same as the cpu_* ports, for port 1.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_size  out  2  RAM size code.
- ram_se  out  1  RAM sign-extend select.
- ram_rdata  in  DATA_W  RAM read data; synchronous, valid the cycle after the address is presented.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset state: IDLE. All outputs 0. last = dbg, so the first tie goes to cpu.
- IDLE, no request pending: stay in IDLE.
- IDLE, any request pending, at the next edge:
  - Pick the winner.
  - Latch the winner's we/addr/wdata/size/se into the command registers.
  - Set the owner register.
  - Pulse the winner's gnt for the following cycle.
  - Go to ISSUE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the port other than last wins.
  - last is updated to the winner at grant.
- ISSUE:
  - ram_addr/ram_wdata/ram_size/ram_se are driven from the command registers.
  - ram_we = latched we, asserted in this cycle only.
  - Next state: WAIT.
- WAIT:
  - ram_* keep their values; ram_we = 0.
  - At the exiting edge, the owner's rdata register <= ram_rdata (reads only; writes leave rdata unchanged).
  - At the exiting edge, the owner's done <= 1 for one cycle.
  - Next state: IDLE.
- Latency: req seen at edge E0 → gnt high in cycle E0+1 (ISSUE) → WAIT → done high in cycle E0+3.
- Back-to-back: the IDLE cycle in which done is high may arbitrate again. Peak throughput is one access per 3 cycles.
- Request timing:
  - req withdrawn before grant: no RAM access, no gnt.
  - Requesters must deassert req in the gnt cycle or issue a new command. A req still high in the IDLE cycle after done counts as a new request.
  - Requests arriving during ISSUE/WAIT are ignored until IDLE.
- ram_* hold their last value in IDLE. ram_we is never 1 outside ISSUE.
- Asynchronous reset during ISSUE or WAIT:
  - FSM immediately goes to IDLE; ram_we drops to 0.
  - The aborted access produces no done.
  - rdata registers clear to 0.
- Pulse exclusivity: gnt and done are never high for both ports in the same cycle.
- No width conversion: addr and data pass through unchanged.

Test Plan:
- Single cpu read of addr 0x10, RAM holding 0x12345678 → cpu_gnt in cycle 1, ram_addr = 0x10 with ram_we = 0, cpu_done and cpu_rdata = 0x12345678 in cycle 3; dbg outputs stay 0.
- dbg write of 0xDEADBEEF to 0x20, size 2 → ram_we high for exactly one cycle with ram_addr = 0x20 and ram_wdata = 0xDEADBEEF; dbg_done in cycle 3; dbg_rdata unchanged.
- Simultaneous cpu and dbg reads right after reset → cpu served first. dbg_gnt arrives 3 cycles after cpu_gnt. A repeat tie then goes to dbg.
- cpu_req held continuously while dbg is idle → cpu_gnt pulses every 3 cycles; no dbg activity.
- rst_ asserted during WAIT of a cpu write → ram_we = 0 and state IDLE immediately; no cpu_done; after release, a new request completes normally.
- dbg_req pulsed for a cycle during a cpu ISSUE, then dropped → no dbg grant or access; cpu transaction unaffected.
